// File: rtl/am_pattern_pkg.sv
// Shared definitions for the data-memory byte-lane access path:
// datapath width and the access-width encoding used by decoder, dmem and controller.
package am_pattern_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WHB_WORD = 2'b00,
      WHB_HALF = 2'b01,
      WHB_BYTE = 2'b10,
      WHB_RSVD = 2'b11
   } whb_e;

endpackage : am_pattern_pkg

// File: rtl/am_load_ext.sv
// Combinational load extractor: picks the addressed byte/half out of the raw
// dmem word and zero- or sign-extends it to XLEN.
module am_load_ext
   import am_pattern_pkg::*;
(
   input  logic [1:0]      a,
   input  logic [1:0]      whbM,
   input  logic            lunsigned,
   input  logic            misaligned,
   input  logic [XLEN-1:0] rd_word,
   output logic [XLEN-1:0] rd_ext
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection for byte and halfword loads
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      case (a)
         2'b00:   byte_s = rd_word[7:0];
         2'b01:   byte_s = rd_word[15:8];
         2'b10:   byte_s = rd_word[23:16];
         2'b11:   byte_s = rd_word[31:24];
         default: byte_s = 8'h00;
      endcase
      if (a[1]) begin
         half_s = rd_word[31:16];
      end else begin
         half_s = rd_word[15:0];
      end
   end

   // Width-dependent extension; misaligned and reserved accesses read as zero
   always_comb begin
      rd_ext = {XLEN{1'b0}};
      if (misaligned) begin
         rd_ext = {XLEN{1'b0}};
      end else begin
         case (whb_e'(whbM))
            WHB_WORD: rd_ext = rd_word;
            WHB_HALF: begin
               if (lunsigned) begin
                  rd_ext = {16'h0000, half_s};
               end else begin
                  rd_ext = {{16{half_s[15]}}, half_s};
               end
            end
            WHB_BYTE: begin
               if (lunsigned) begin
                  rd_ext = {24'h000000, byte_s};
               end else begin
                  rd_ext = {{24{byte_s[7]}}, byte_s};
               end
            end
            default:  rd_ext = {XLEN{1'b0}};
         endcase
      end
   end

endmodule : am_load_ext

// File: rtl/am_pattern.sv
// Byte-lane access-pattern unit: byte-write mask decode, store lane steering,
// load extraction, and misaligned-access flag/counter.
module am_pattern
   import am_pattern_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      a,
   input  logic [1:0]      whbM,
   input  logic            lunsigned,
   input  logic            access_valid,
   input  logic [XLEN-1:0] wd,
   input  logic [XLEN-1:0] rd_word,
   output logic [3:0]      amp,
   output logic [XLEN-1:0] wd_lanes,
   output logic [XLEN-1:0] rd_ext,
   output logic            misaligned,
   output logic            misalign_sticky,
   output logic [7:0]      misalign_count
);

   logic [3:0]      amp_s;
   logic [XLEN-1:0] wd_lanes_s;
   logic            misaligned_s;
   logic            sticky_r;
   logic [7:0]      count_r;

   // Mask decode, misalignment detect and store steering
   always_comb begin
      amp_s        = 4'b0000;
      misaligned_s = 1'b0;
      wd_lanes_s   = wd;
      case (whb_e'(whbM))
         WHB_WORD: begin
            if (a == 2'b00) begin
               amp_s = 4'b1111;
            end else begin
               misaligned_s = 1'b1;
            end
         end
         WHB_HALF: begin
            wd_lanes_s = {2{wd[15:0]}};
            if (a == 2'b00) begin
               amp_s = 4'b0011;
            end else if (a == 2'b10) begin
               amp_s = 4'b1100;
            end else begin
               misaligned_s = 1'b1;
            end
         end
         WHB_BYTE: begin
            wd_lanes_s = {4{wd[7:0]}};
            amp_s      = 4'b0001 << a;
         end
         default: begin
            amp_s        = 4'b0000;
            misaligned_s = 1'b0;
            wd_lanes_s   = wd;
         end
      endcase
   end

   am_load_ext u_load_ext (
      .a          (a),
      .whbM       (whbM),
      .lunsigned  (lunsigned),
      .misaligned (misaligned_s),
      .rd_word    (rd_word),
      .rd_ext     (rd_ext)
   );

   // Misalignment bookkeeping; only reset clears it, count saturates at 255
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_r <= 1'b0;
         count_r  <= 8'd0;
      end else if (access_valid && misaligned_s) begin
         sticky_r <= 1'b1;
         if (count_r != 8'hFF) begin
            count_r <= count_r + 8'd1;
         end else begin
            count_r <= count_r;
         end
      end else begin
         sticky_r <= sticky_r;
         count_r  <= count_r;
      end
   end

   assign amp             = amp_s;
   assign wd_lanes        = wd_lanes_s;
   assign misaligned      = misaligned_s;
   assign misalign_sticky = sticky_r;
   assign misalign_count  = count_r;

endmodule : am_pattern

// File: tb/tb_am_pattern.sv
// Self-checking bench for am_pattern: table of directed combinational vectors
// plus hand-written sequences for the misalignment counter, saturation and reset.
module tb_am_pattern;

   logic        clk;
   logic        reset;
   logic [1:0]  a;
   logic [1:0]  whbM;
   logic        lunsigned;
   logic        access_valid;
   logic [31:0] wd;
   logic [31:0] rd_word;
   logic [3:0]  amp;
   logic [31:0] wd_lanes;
   logic [31:0] rd_ext;
   logic        misaligned;
   logic        misalign_sticky;
   logic [7:0]  misalign_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]  whb;
      logic [1:0]  a;
      logic        lu;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [3:0]  e_amp;
      logic [31:0] e_wdl;
      logic [31:0] e_rd;
      logic        e_mis;
   } vec_t;

   vec_t vecs[20];

   am_pattern dut (
      .clk             (clk),
      .reset           (reset),
      .a               (a),
      .whbM            (whbM),
      .lunsigned       (lunsigned),
      .access_valid    (access_valid),
      .wd              (wd),
      .rd_word         (rd_word),
      .amp             (amp),
      .wd_lanes        (wd_lanes),
      .rd_ext          (rd_ext),
      .misaligned      (misaligned),
      .misalign_sticky (misalign_sticky),
      .misalign_count  (misalign_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b10, 2'd0, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0001, 32'h44444444, 32'h00000000, 1'b0};
      vecs[1]  = '{2'b10, 2'd1, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0010, 32'h44444444, 32'h0000007F, 1'b0};
      vecs[2]  = '{2'b10, 2'd2, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0100, 32'h44444444, 32'hFFFFFFF1, 1'b0};
      vecs[3]  = '{2'b10, 2'd2, 1'b1, 32'h11223344, 32'h80F17F00, 4'b0100, 32'h44444444, 32'h000000F1, 1'b0};
      vecs[4]  = '{2'b10, 2'd3, 1'b0, 32'h11223344, 32'h80F17F00, 4'b1000, 32'h44444444, 32'hFFFFFF80, 1'b0};
      vecs[5]  = '{2'b10, 2'd3, 1'b1, 32'h11223344, 32'h80F17F00, 4'b1000, 32'h44444444, 32'h00000080, 1'b0};
      vecs[6]  = '{2'b01, 2'd0, 1'b0, 32'hAAAA8001, 32'h80F17F00, 4'b0011, 32'h80018001, 32'h00007F00, 1'b0};
      vecs[7]  = '{2'b01, 2'd2, 1'b0, 32'hAAAA8001, 32'h80F17F00, 4'b1100, 32'h80018001, 32'hFFFF80F1, 1'b0};
      vecs[8]  = '{2'b01, 2'd2, 1'b1, 32'hAAAA8001, 32'h80F17F00, 4'b1100, 32'h80018001, 32'h000080F1, 1'b0};
      vecs[9]  = '{2'b01, 2'd1, 1'b0, 32'hAAAA8001, 32'h80F17F00, 4'b0000, 32'h80018001, 32'h00000000, 1'b1};
      vecs[10] = '{2'b01, 2'd3, 1'b1, 32'hAAAA8001, 32'h80F17F00, 4'b0000, 32'h80018001, 32'h00000000, 1'b1};
      vecs[11] = '{2'b00, 2'd0, 1'b0, 32'h11223344, 32'h80F17F00, 4'b1111, 32'h11223344, 32'h80F17F00, 1'b0};
      vecs[12] = '{2'b00, 2'd1, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0000, 32'h11223344, 32'h00000000, 1'b1};
      vecs[13] = '{2'b00, 2'd2, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0000, 32'h11223344, 32'h00000000, 1'b1};
      vecs[14] = '{2'b00, 2'd3, 1'b1, 32'h11223344, 32'h80F17F00, 4'b0000, 32'h11223344, 32'h00000000, 1'b1};
      vecs[15] = '{2'b11, 2'd0, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0000, 32'h11223344, 32'h00000000, 1'b0};
      vecs[16] = '{2'b11, 2'd1, 1'b0, 32'h11223344, 32'h80F17F00, 4'b0000, 32'h11223344, 32'h00000000, 1'b0};
      vecs[17] = '{2'b10, 2'd1, 1'b1, 32'hDEADBEEF, 32'h1234ABCD, 4'b0010, 32'hEFEFEFEF, 32'h000000AB, 1'b0};
      vecs[18] = '{2'b01, 2'd0, 1'b0, 32'hDEADBEEF, 32'h1234ABCD, 4'b0011, 32'hBEEFBEEF, 32'hFFFFABCD, 1'b0};
      vecs[19] = '{2'b01, 2'd2, 1'b0, 32'hDEADBEEF, 32'h1234ABCD, 4'b1100, 32'hBEEFBEEF, 32'h00001234, 1'b0};

      reset        = 1'b1;
      a            = 2'd0;
      whbM         = 2'b00;
      lunsigned    = 1'b0;
      access_valid = 1'b0;
      wd           = 32'h0;
      rd_word      = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_sticky", {31'd0, misalign_sticky}, 32'd0);
      chk("reset_count", {24'd0, misalign_count}, 32'd0);
      reset = 1'b0;

      // combinational table, access_valid low so the counter must not move
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         whbM      = vecs[i].whb;
         a         = vecs[i].a;
         lunsigned = vecs[i].lu;
         wd        = vecs[i].wd;
         rd_word   = vecs[i].rd;
         @(negedge clk);
         chk($sformatf("amp[%0d]", i), {28'd0, amp}, {28'd0, vecs[i].e_amp});
         chk($sformatf("wd_lanes[%0d]", i), wd_lanes, vecs[i].e_wdl);
         chk($sformatf("rd_ext[%0d]", i), rd_ext, vecs[i].e_rd);
         chk($sformatf("misaligned[%0d]", i), {31'd0, misaligned}, {31'd0, vecs[i].e_mis});
      end
      next_cycle();
      chk("gated_count", {24'd0, misalign_count}, 32'd0);
      chk("gated_sticky", {31'd0, misalign_sticky}, 32'd0);

      // misaligned word for three cycles
      whbM = 2'b00; a = 2'd1; rd_word = 32'h80F17F00; access_valid = 1'b1;
      @(negedge clk);
      chk("mw_amp", {28'd0, amp}, 32'd0);
      chk("mw_rd_ext", rd_ext, 32'd0);
      chk("mw_mis", {31'd0, misaligned}, 32'd1);
      chk("mw_sticky_pre", {31'd0, misalign_sticky}, 32'd0);
      next_cycle();
      chk("mw_sticky_1", {31'd0, misalign_sticky}, 32'd1);
      chk("mw_count_1", {24'd0, misalign_count}, 32'd1);
      next_cycle();
      next_cycle();
      access_valid = 1'b0;
      chk("mw_count_3", {24'd0, misalign_count}, 32'd3);

      // reserved width with valid: not misaligned, no count
      whbM = 2'b11; a = 2'd1; access_valid = 1'b1;
      next_cycle();
      next_cycle();
      chk("rsvd_count", {24'd0, misalign_count}, 32'd3);
      // misaligned half without valid
      whbM = 2'b01; a = 2'd3; access_valid = 1'b0;
      next_cycle();
      next_cycle();
      chk("nv_count", {24'd0, misalign_count}, 32'd3);

      // saturation
      access_valid = 1'b1;
      repeat (300) next_cycle();
      chk("sat_count", {24'd0, misalign_count}, 32'd255);
      chk("sat_sticky", {31'd0, misalign_sticky}, 32'd1);
      next_cycle();
      chk("sat_hold", {24'd0, misalign_count}, 32'd255);

      // asynchronous reset mid-cycle
      access_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_count", {24'd0, misalign_count}, 32'd0);
      chk("arst_sticky", {31'd0, misalign_sticky}, 32'd0);
      chk("arst_mis_comb", {31'd0, misaligned}, 32'd1);
      // access present when reset drops but gone before the edge: not counted
      access_valid = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      access_valid = 1'b0;
      next_cycle();
      chk("post_rst_count", {24'd0, misalign_count}, 32'd0);
      access_valid = 1'b1;
      next_cycle();
      access_valid = 1'b0;
      chk("post_rst_count1", {24'd0, misalign_count}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_am_pattern

// File: doc/am_pattern.md
# am_pattern

Byte-lane access-pattern unit for the data-memory path. It decodes the low address bits and the access width (word/half/byte) into a 4-bit byte-write mask, steers store data onto byte lanes, and extracts and extends load data. It also flags and counts misaligned accesses. It sits between the MEM-stage datapath and `dmem`, and `dmem` consumes `amp` in the same cycle.

## Interface
- No parameters; `XLEN` = 32, taken from the shared defines.
- `clk`  in  1  system clock; only the misalignment bookkeeping registers use it.
- `reset`  in  1  asynchronous, active-high reset.
- `a`  in  2  byte offset, i.e. address bits [1:0].
- `whbM`  in  2  access width: 00 word, 01 half, 10 byte, 11 reserved.
- `lunsigned`  in  1  load extension: 1 zero-extends, 0 sign-extends.
- `access_valid`  in  1  a load or store is in MEM this cycle.
- `wd`  in  32  raw store data from the register file.
- `rd_word`  in  32  raw word read from `dmem`.
- `amp`  out  4  byte-enable mask; bit i enables byte lane i, i.e. bits [8i+7:8i].
- `wd_lanes`  out  32  store data steered to the byte lanes.
- `rd_ext`  out  32  extracted and extended load data.
- `misaligned`  out  1  the current access is misaligned (combinational).
- `misalign_sticky`  out  1  latched misalignment flag.
- `misalign_count`  out  8  saturating count of misaligned accesses.

## Operation
- Mask, from `whbM` and `a`:
  - byte: `a` = 0/1/2/3 gives `amp` = 0001/0010/0100/1000.
  - half: `a` = 00 gives 0011; `a` = 10 gives 1100; `a` = 01 or 11 gives 0000 and `misaligned` = 1.
  - word: `a` = 00 gives 1111; any other `a` gives 0000 and `misaligned` = 1.
  - reserved width (11): `amp` = 0000 and `misaligned` = 0.
- `misaligned` is purely combinational and is independent of `access_valid`.
- Store steering:
  - byte: `wd_lanes` = `{4{wd[7:0]}}`.
  - half: `wd_lanes` = `{2{wd[15:0]}}`.
  - word or reserved: `wd_lanes` = `wd`.
  - Lanes not enabled by `amp` are don't-care for `dmem`, but `wd_lanes` must still be exactly as listed above.
- Load extraction:
  - byte: select `rd_word[8a+7:8a]`.
  - half: select `rd_word[15:0]` when `a[1]` = 0, else `rd_word[31:16]`.
  - byte and half results are extended to 32 bits, with zeros if `lunsigned` = 1 and with the sign bit if 0.
  - word: `rd_ext` = `rd_word`.
  - misaligned or reserved: `rd_ext` = 0.
- Bookkeeping, updated on the rising edge when `access_valid` and `misaligned` are both 1:
  - `misalign_sticky` is set to 1.
  - `misalign_count` increments and saturates at 255.
  - Nothing clears either register except `reset`.

## Timing
- `amp`, `wd_lanes`, `rd_ext` and `misaligned` are zero-latency combinational outputs, valid in the same cycle as the inputs.
- `misalign_sticky` and `misalign_count` update on the rising edge of `clk`; the new value is visible the cycle after the access.
- Reset:
  - `reset` asserted drives `misalign_sticky` = 0 and `misalign_count` = 0 immediately, without waiting for `clk`.
  - The combinational outputs are unaffected by `reset`.
  - A misaligned access in the same cycle that `reset` deasserts is not counted unless it is present at the next rising edge.
- When `misalign_count` = 255 and another misaligned access occurs, the count stays 255 and the sticky flag stays 1.

## Structure
- The width encodings (WORD = 2'b00, HALF = 2'b01, BYTE = 2'b10) and `XLEN` belong in the shared defines/package, used by the decoder, `dmem` and the controller.
- One natural sub-module: `am_load_ext`, the combinational load extractor and extender.
- The mask decoder, store steering and counter stay in the top module.

## Test plan
- Byte sweep: `whbM` = 10, `a` = 0..3, `wd` = 0x11223344 → `amp` = 0001/0010/0100/1000 and `wd_lanes` = 0x44444444.
- Half aligned: `whbM` = 01, `a` = 10, `wd` = 0xAAAA8001 → `amp` = 1100, `wd_lanes` = 0x80018001, `misaligned` = 0.
- Loads: `rd_word` = 0x80F17F00.
  - byte, `a` = 2, `lunsigned` = 0 → `rd_ext` = 0xFFFFFFF1; with `lunsigned` = 1 → 0x000000F1.
  - half, `a` = 2, `lunsigned` = 0 → `rd_ext` = 0xFFFF80F1.
- Misaligned word: `whbM` = 00, `a` = 01, `access_valid` = 1 for 3 cycles → `amp` = 0000, `rd_ext` = 0, `misaligned` = 1, `misalign_sticky` = 1 after the first edge, `misalign_count` = 3.
- Saturation and reset:
  - Drive 300 misaligned accesses → `misalign_count` = 255.
  - Assert `reset` between clock edges → `misalign_count` = 0 and `misalign_sticky` = 0 immediately.
- Reserved width and `access_valid` gating:
  - `whbM` = 11 → `amp` = 0000, `misaligned` = 0, counter unchanged.
  - Misaligned half with `access_valid` = 0 → counter unchanged.
